// File: rtl/placar_scheduler.sv
// Scheduler that time-shares one digit recogniser across the score digit slots and commits a binary score.
// Latency: 1 + NUM_DIGITS*(L+2) + 1 cycles from iFrameEnd to oScoreValid/oError, where L is the processor latency.
// Backpressure: none; an iFrameEnd that arrives while busy is dropped and flagged on oOverrun.
// Build option: define SCORE_STABLE_EN to commit only after two consecutive identical error-free frames.
module placar_scheduler #(
    parameter int NUM_DIGITS = 7,
    parameter int TIMEOUT    = 1023,
    parameter int SCORE_W    = 24
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iFrameEnd,
    output logic [2:0]              oDigitSel,
    output logic                    oProcStart,
    input  logic                    iProcDone,
    input  logic [3:0]              iProcDigit,
    output logic [4*NUM_DIGITS-1:0] oDigits,
    output logic [SCORE_W-1:0]      oScore,
    output logic                    oScoreValid,
    output logic                    oBusy,
    output logic                    oError,
    output logic                    oOverrun
);

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]      LAST_SLOT  = 3'(NUM_DIGITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_COMMIT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_slot;
    logic [TW-1:0]             r_timer;
    logic [3:0]                r_code;
    logic [SCORE_W-1:0]        r_acc;
    logic                      r_err;
    logic [4*NUM_DIGITS-1:0]   r_buf;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [SCORE_W-1:0]        r_score;
    logic                      r_score_vld;
    logic                      r_error;
    logic                      w_timeout;
    logic [SCORE_W-1:0]        w_acc_nxt;
`ifdef SCORE_STABLE_EN
    logic [4*NUM_DIGITS-1:0]   r_cand;
    logic                      r_cand_vld;
`endif

    // The timer counts completed WAIT cycles; the slot is aborted after TIMEOUT of them.
    assign w_timeout = (r_timer == TIMER_LAST);
    // acc*10 + code built from shifts, wrapping at SCORE_W bits.
    assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + SCORE_W'(r_code);

    assign oDigitSel   = r_slot;
    assign oProcStart  = (r_state == S_ISSUE);
    assign oBusy       = (r_state != S_IDLE);
    assign oOverrun    = iFrameEnd && (r_state != S_IDLE);
    assign oDigits     = r_digits;
    assign oScore      = r_score;
    assign oScoreValid = r_score_vld;
    assign oError      = r_error;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: walk the slots ISSUE -> WAIT -> STORE, then COMMIT once the last slot is stored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (iFrameEnd) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT:   if (iProcDone || w_timeout) w_state_nxt = S_STORE;
            S_STORE:  w_state_nxt = (r_slot == LAST_SLOT) ? S_COMMIT : S_ISSUE;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: slot counter, timer, code capture, accumulation and the committed outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_slot      <= 3'd1;
            r_timer     <= '0;
            r_code      <= 4'hF;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_buf       <= {NUM_DIGITS{4'hF}};
            r_digits    <= {NUM_DIGITS{4'hF}};
            r_score     <= '0;
            r_score_vld <= 1'b0;
            r_error     <= 1'b0;
`ifdef SCORE_STABLE_EN
            r_cand      <= {NUM_DIGITS{4'hF}};
            r_cand_vld  <= 1'b0;
`endif
        end else begin
            r_score_vld <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_slot <= 3'd1;
                    if (iFrameEnd) begin
                        r_acc <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A done arriving on the timeout cycle still delivers its code.
                    if (iProcDone) begin
                        r_code <= iProcDigit;
                    end else if (w_timeout) begin
                        r_code <= 4'hF;
                        r_err  <= 1'b1;
                    end
                end
                S_STORE: begin
                    for (int k = 1; k <= NUM_DIGITS; k++) begin
                        if (r_slot == 3'(k)) r_buf[4*k-4 +: 4] <= r_code;
                    end
                    if (r_code <= 4'd9) begin
                        r_acc <= w_acc_nxt;
                    end else begin
                        r_err <= 1'b1;
                    end
                    if (r_slot != LAST_SLOT) r_slot <= r_slot + 3'd1;
                end
                S_COMMIT: begin
                    r_slot <= 3'd1;
                    if (!r_err) begin
`ifdef SCORE_STABLE_EN
                        // Only a repeat of the held candidate is trusted enough to publish.
                        if (r_cand_vld && (r_cand == r_buf)) begin
                            r_digits    <= r_buf;
                            r_score     <= r_acc;
                            r_score_vld <= 1'b1;
                        end
                        r_cand     <= r_buf;
                        r_cand_vld <= 1'b1;
`else
                        r_digits    <= r_buf;
                        r_score     <= r_acc;
                        r_score_vld <= 1'b1;
`endif
                    end else begin
                        r_error <= 1'b1;
`ifdef SCORE_STABLE_EN
                        r_cand_vld <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_slot <= 3'd1;
                end
            endcase
        end
    end

endmodule
